// File: rtl/ndata_width_resizer.sv
// -----------------------------------------------------------------------------
// ndata_width_resizer
//
// Converts a lane-based element stream between IN_WIDTH and OUT_WIDTH lanes,
// where one width is an integer multiple of the other (RATIO = max/min).
//   - Up mode   (OUT_WIDTH > IN_WIDTH): packs up to RATIO input beats into one
//     output beat. A group closes early on i_in_last; unfilled slots carry
//     keep = 0.
//   - Down mode (IN_WIDTH > OUT_WIDTH): splits one input beat into RATIO output
//     chunks, lowest lanes first.
//   - Equal mode: pure combinational passthrough.
// Lane 0 is the earliest element in the stream.
//
// Optional build macro:
//   NDATA_RESIZER_DROP_EMPTY_EN - down mode only. Chunks whose keep is all zero
//   are skipped. A fully empty last beat still emits one chunk (keep = 0,
//   last = 1). A fully empty non-last beat is consumed without producing
//   output.
//
// Ports:
//   clk          clock
//   rst_n        synchronous reset, active-low
//   i_in_data    input elements, IN_WIDTH lanes of data_t
//   i_in_keep    per-lane keep of the input beat
//   i_in_last    input beat ends a packet
//   i_in_valid   input beat valid
//   o_in_ready   resizer can accept an input beat
//   o_out_data   output elements, OUT_WIDTH lanes of data_t
//   o_out_keep   per-lane keep of the output beat
//   o_out_last   output beat ends a packet
//   o_out_valid  output beat valid
//   i_out_ready  downstream accepts the output beat
// -----------------------------------------------------------------------------
module ndata_width_resizer #(
    parameter type data_t    = logic [31:0],
    parameter int  IN_WIDTH  = 8,
    parameter int  OUT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  data_t [IN_WIDTH-1:0]  i_in_data,
    input  logic  [IN_WIDTH-1:0]  i_in_keep,
    input  logic                  i_in_last,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output data_t [OUT_WIDTH-1:0] o_out_data,
    output logic  [OUT_WIDTH-1:0] o_out_keep,
    output logic                  o_out_last,
    output logic                  o_out_valid,
    input  logic                  i_out_ready
);

    localparam int RATIO = (IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH / OUT_WIDTH)
                                                  : (OUT_WIDTH / IN_WIDTH);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

`ifdef NDATA_RESIZER_DROP_EMPTY_EN
    // One bit per chunk: set when the chunk carries at least one kept lane.
    function automatic logic [RATIO-1:0] f_nonempty(
        input logic [RATIO-1:0][OUT_WIDTH-1:0] keep
    );
        logic [RATIO-1:0] nz;
        for (int c = 0; c < RATIO; c++) begin
            nz[c] = |keep[c];
        end
        return nz;
    endfunction

    // Lowest non-empty chunk strictly above floor_c (0 when there is none).
    function automatic logic [CNT_W-1:0] f_lowest_above(
        input logic [RATIO-1:0] nz,
        input int               floor_c
    );
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int c = RATIO - 1; c >= 0; c--) begin
            if (nz[c] && (c > floor_c)) begin
                idx = CNT_W'(c);
            end
        end
        return idx;
    endfunction

    function automatic logic f_any_above(
        input logic [RATIO-1:0] nz,
        input int               floor_c
    );
        logic any;
        any = 1'b0;
        for (int c = 0; c < RATIO; c++) begin
            if (nz[c] && (c > floor_c)) begin
                any = 1'b1;
            end
        end
        return any;
    endfunction
`endif

    generate
        if (((IN_WIDTH % OUT_WIDTH) != 0) && ((OUT_WIDTH % IN_WIDTH) != 0)) begin : g_bad_ratio
            $error("ndata_width_resizer: IN_WIDTH and OUT_WIDTH must be integer multiples");
        end else if (OUT_WIDTH > IN_WIDTH) begin : g_up
            data_t [RATIO-1:0][IN_WIDTH-1:0] r_acc_data;
            logic  [RATIO-1:0][IN_WIDTH-1:0] r_acc_keep;
            logic  [CNT_W-1:0]               r_slot;
            data_t [RATIO-1:0][IN_WIDTH-1:0] r_out_data;
            logic  [RATIO-1:0][IN_WIDTH-1:0] r_out_keep;
            logic                            r_out_last;
            logic                            r_out_valid;

            data_t [RATIO-1:0][IN_WIDTH-1:0] w_merge_data;
            logic  [RATIO-1:0][IN_WIDTH-1:0] w_merge_keep;
            logic                            w_in_ready;
            logic                            w_in_fire;
            logic                            w_complete;

            // Output register is free, or it drains this very cycle.
            assign w_in_ready = !r_out_valid || i_out_ready;
            assign w_in_fire  = i_in_valid && w_in_ready;
            assign w_complete = w_in_fire && ((r_slot == CNT_W'(RATIO - 1)) || i_in_last);

            // Accumulator with the current beat dropped into its slot; this is
            // what loads the output register when the group closes. Slots past
            // the current one still hold keep = 0 from the last clear.
            always_comb begin
                w_merge_data         = r_acc_data;
                w_merge_keep         = r_acc_keep;
                w_merge_data[r_slot] = i_in_data;
                w_merge_keep[r_slot] = i_in_keep;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_slot      <= '0;
                    r_acc_keep  <= '0;
                    r_out_keep  <= '0;
                    r_out_valid <= 1'b0;
                end else if (w_complete) begin
                    r_slot      <= '0;
                    r_acc_keep  <= '0;
                    r_out_keep  <= w_merge_keep;
                    r_out_valid <= 1'b1;
                end else begin
                    if (w_in_fire) begin
                        r_acc_keep[r_slot] <= i_in_keep;
                        r_slot             <= r_slot + CNT_W'(1);
                    end
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_in_fire && !w_complete) begin
                    r_acc_data[r_slot] <= i_in_data;
                end
                if (w_complete) begin
                    r_out_data <= w_merge_data;
                    r_out_last <= i_in_last;
                end
            end

            assign o_in_ready  = w_in_ready;
            assign o_out_data  = r_out_data;
            assign o_out_keep  = r_out_keep;
            assign o_out_last  = r_out_last;
            assign o_out_valid = r_out_valid;
        end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
            data_t [RATIO-1:0][OUT_WIDTH-1:0] r_buf_data;
            logic  [RATIO-1:0][OUT_WIDTH-1:0] r_buf_keep;
            logic                             r_buf_last;
            logic                             r_full;
            logic  [CNT_W-1:0]                r_chunk;

            logic                             w_final;
            logic  [CNT_W-1:0]                w_next_chunk;
            logic  [CNT_W-1:0]                w_load_chunk;
            logic                             w_load_full;
            logic                             w_in_ready;
            logic                             w_in_fire;
            logic                             w_out_fire;

`ifdef NDATA_RESIZER_DROP_EMPTY_EN
            logic  [RATIO-1:0]                w_nz_buf;
            logic  [RATIO-1:0]                w_nz_in;

            assign w_nz_buf     = f_nonempty(r_buf_keep);
            assign w_nz_in      = f_nonempty(i_in_keep);
            // Final when no non-empty chunk remains above the current one; an
            // all-empty buffer sits at chunk 0 and is final immediately.
            assign w_final      = !f_any_above(w_nz_buf, int'(r_chunk));
            assign w_next_chunk = f_lowest_above(w_nz_buf, int'(r_chunk));
            assign w_load_chunk = f_lowest_above(w_nz_in, -1);
            // An all-empty non-last beat is swallowed on acceptance.
            assign w_load_full  = (|w_nz_in) || i_in_last;
`else
            assign w_final      = (r_chunk == CNT_W'(RATIO - 1));
            assign w_next_chunk = r_chunk + CNT_W'(1);
            assign w_load_chunk = '0;
            assign w_load_full  = 1'b1;
`endif

            // Refill in the same cycle the final chunk leaves: no output gap.
            assign w_in_ready = !r_full || (w_final && i_out_ready);
            assign w_in_fire  = i_in_valid && w_in_ready;
            assign w_out_fire = r_full && i_out_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_full     <= 1'b0;
                    r_chunk    <= '0;
                    r_buf_keep <= '0;
                end else if (w_in_fire) begin
                    r_full     <= w_load_full;
                    r_chunk    <= w_load_chunk;
                    r_buf_keep <= i_in_keep;
                end else if (w_out_fire) begin
                    if (w_final) begin
                        r_full  <= 1'b0;
                        r_chunk <= '0;
                    end else begin
                        r_chunk <= w_next_chunk;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_in_fire) begin
                    r_buf_data <= i_in_data;
                    r_buf_last <= i_in_last;
                end
            end

            assign o_in_ready  = w_in_ready;
            assign o_out_data  = r_buf_data[r_chunk];
            assign o_out_keep  = r_buf_keep[r_chunk];
            assign o_out_last  = r_buf_last && w_final;
            assign o_out_valid = r_full;
        end else begin : g_equal
            logic w_unused;

            assign w_unused    = clk ^ rst_n;
            assign o_in_ready  = i_out_ready;
            assign o_out_data  = i_in_data;
            assign o_out_keep  = i_in_keep;
            assign o_out_last  = i_in_last;
            assign o_out_valid = i_in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ndata_width_resizer.sv
// -----------------------------------------------------------------------------
// tb_ndata_width_resizer
//
// Drives an 8->32 upsizer and a 32->8 downsizer. Expected output beats are
// derived from whole packets / whole input beats and queued; independent
// monitors pop and compare every accepted output beat and watch that stalled
// outputs stay frozen.
// -----------------------------------------------------------------------------
module tb_ndata_width_resizer;

    localparam int UI = 8;
    localparam int UO = 32;
    localparam int UR = 4;
    localparam int DI = 32;
    localparam int DO = 8;
    localparam int DR = 4;

    logic clk;
    logic rst_n;

    logic [UI-1:0][31:0] u_in_data;
    logic [UI-1:0]       u_in_keep;
    logic                u_in_last, u_in_valid, u_in_ready;
    logic [UO-1:0][31:0] u_out_data;
    logic [UO-1:0]       u_out_keep;
    logic                u_out_last, u_out_valid, u_out_ready;

    logic [DI-1:0][31:0] d_in_data;
    logic [DI-1:0]       d_in_keep;
    logic                d_in_last, d_in_valid, d_in_ready;
    logic [DO-1:0][31:0] d_out_data;
    logic [DO-1:0]       d_out_keep;
    logic                d_out_last, d_out_valid, d_out_ready;

    ndata_width_resizer #(.IN_WIDTH(UI), .OUT_WIDTH(UO)) u_up (
        .clk(clk), .rst_n(rst_n),
        .i_in_data(u_in_data), .i_in_keep(u_in_keep), .i_in_last(u_in_last),
        .i_in_valid(u_in_valid), .o_in_ready(u_in_ready),
        .o_out_data(u_out_data), .o_out_keep(u_out_keep), .o_out_last(u_out_last),
        .o_out_valid(u_out_valid), .i_out_ready(u_out_ready)
    );

    ndata_width_resizer #(.IN_WIDTH(DI), .OUT_WIDTH(DO)) u_down (
        .clk(clk), .rst_n(rst_n),
        .i_in_data(d_in_data), .i_in_keep(d_in_keep), .i_in_last(d_in_last),
        .i_in_valid(d_in_valid), .o_in_ready(d_in_ready),
        .o_out_data(d_out_data), .o_out_keep(d_out_keep), .o_out_last(d_out_last),
        .o_out_valid(d_out_valid), .i_out_ready(d_out_ready)
    );

    typedef struct {
        logic [UO-1:0][31:0] data;
        logic [UO-1:0]       keep;
        logic                last;
    } up_exp_t;

    typedef struct {
        logic [DO-1:0][31:0] data;
        logic [DO-1:0]       keep;
        logic                last;
    } dn_exp_t;

    up_exp_t uq[$];
    dn_exp_t dq[$];
    int      u_lat_q[$];
    bit      u_lat_en;

    int n_tests;
    int n_fail;
    int cyc;

    bit rdy_rand;
    bit u_rdy_force;
    bit d_rdy_force;

    // Current upsizer packet: elements in stream order and keep per beat.
    logic [31:0]   pk_el [0:127];
    logic [UI-1:0] pk_keep [0:15];
    int            pk_nb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got unfinished run, expected completion");
        $fatal(1);
    end

    task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready generator: random, or a directed level set by the test sequence.
    initial begin
        u_out_ready = 1'b1;
        d_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            u_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : u_rdy_force;
            d_out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : d_rdy_force;
        end
    end

    // ---------------- upsizer reference: packet -> output words ----------------
    task automatic up_model();
        int nw;
        nw = (pk_nb + UR - 1) / UR;
        for (int w = 0; w < nw; w++) begin
            up_exp_t e;
            e.data = '0;
            e.keep = '0;
            e.last = (w == nw - 1);
            for (int k = 0; k < UR; k++) begin
                int b;
                b = w * UR + k;
                if (b < pk_nb) begin
                    for (int j = 0; j < UI; j++) begin
                        e.data[k * UI + j] = pk_el[b * UI + j];
                        e.keep[k * UI + j] = pk_keep[b][j];
                    end
                end
            end
            uq.push_back(e);
        end
    endtask

    task automatic up_beat(input logic [UI-1:0][31:0] d, input logic [UI-1:0] k,
                           input logic l, input bit completes);
        int waitc;
        waitc = 0;
        u_in_data  = d;
        u_in_keep  = k;
        u_in_last  = l;
        u_in_valid = 1'b1;
        @(negedge clk);
        while (!u_in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!u_in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL up_in_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        if (u_lat_en && completes) u_lat_q.push_back(cyc);
    endtask

    task automatic up_drive_pkt(input bit gaps);
        for (int b = 0; b < pk_nb; b++) begin
            logic [UI-1:0][31:0] d;
            for (int j = 0; j < UI; j++) d[j] = pk_el[b * UI + j];
            up_beat(d, pk_keep[b], (b == pk_nb - 1), ((b % UR) == UR - 1) || (b == pk_nb - 1));
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // ---------------- downsizer reference: input beat -> chunks ----------------
    task automatic d_model(input logic [DR-1:0][DO-1:0][31:0] d,
                           input logic [DR-1:0][DO-1:0] k, input logic l);
        dn_exp_t e;
        int      lastc;
        lastc = -1;
        for (int c = 0; c < DR; c++) if (k[c] != '0) lastc = c;
`ifdef NDATA_RESIZER_DROP_EMPTY_EN
        if (lastc < 0) begin
            if (l) begin
                e.data = d[0];
                e.keep = '0;
                e.last = 1'b1;
                dq.push_back(e);
            end
        end else begin
            for (int c = 0; c < DR; c++) begin
                if (k[c] != '0) begin
                    e.data = d[c];
                    e.keep = k[c];
                    e.last = l && (c == lastc);
                    dq.push_back(e);
                end
            end
        end
`else
        for (int c = 0; c < DR; c++) begin
            e.data = d[c];
            e.keep = k[c];
            e.last = l && (c == DR - 1);
            dq.push_back(e);
        end
`endif
    endtask

    task automatic d_send(input logic [DI-1:0][31:0] d, input logic [DI-1:0] k, input logic l);
        int waitc;
        waitc = 0;
        d_model(d, k, l);
        d_in_data  = d;
        d_in_keep  = k;
        d_in_last  = l;
        d_in_valid = 1'b1;
        @(negedge clk);
        while (!d_in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!d_in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL dn_in_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    // ---------------- monitors ----------------
    initial begin
        up_exp_t             e;
        logic [UO-1:0][31:0] pd;
        logic [UO-1:0]       pk;
        logic                pl;
        bit                  stall;
        int                  bad;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check_val("up_hold_valid", u_out_valid, 1);
                    n_tests++;
                    if (u_out_data !== pd || u_out_keep !== pk || u_out_last !== pl) begin
                        n_fail++;
                        $display("FAIL up_hold: got keep %h last %0d, expected held keep %h last %0d",
                                 u_out_keep, u_out_last, pk, pl);
                    end
                end
                if (u_out_valid && u_out_ready) begin
                    if (uq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL up_unexpected: got beat keep %h, expected no beat", u_out_keep);
                    end else begin
                        e = uq.pop_front();
                        check_val("up_keep", u_out_keep, e.keep);
                        check_val("up_last", u_out_last, e.last);
                        bad = -1;
                        for (int j = 0; j < UO; j++)
                            if (e.keep[j] && u_out_data[j] !== e.data[j] && bad < 0) bad = j;
                        n_tests++;
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL up_data lane %0d: got %h expected %h",
                                     bad, u_out_data[bad], e.data[bad]);
                        end
                        if (u_lat_en && u_lat_q.size() > 0)
                            check_val("up_latency_cycle", cyc, u_lat_q.pop_front());
                    end
                end
                stall = u_out_valid && !u_out_ready;
                pd = u_out_data;
                pk = u_out_keep;
                pl = u_out_last;
            end
        end
    end

    initial begin
        dn_exp_t             e;
        logic [DO-1:0][31:0] pd;
        logic [DO-1:0]       pk;
        logic                pl;
        bit                  stall;
        int                  bad;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check_val("dn_hold_valid", d_out_valid, 1);
                    n_tests++;
                    if (d_out_data !== pd || d_out_keep !== pk || d_out_last !== pl) begin
                        n_fail++;
                        $display("FAIL dn_hold: got keep %h last %0d, expected held keep %h last %0d",
                                 d_out_keep, d_out_last, pk, pl);
                    end
                end
                if (d_out_valid && d_out_ready) begin
                    if (dq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dn_unexpected: got chunk keep %h, expected no chunk", d_out_keep);
                    end else begin
                        e = dq.pop_front();
                        check_val("dn_keep", d_out_keep, e.keep);
                        check_val("dn_last", d_out_last, e.last);
                        bad = -1;
                        for (int j = 0; j < DO; j++)
                            if (e.keep[j] && d_out_data[j] !== e.data[j] && bad < 0) bad = j;
                        n_tests++;
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL dn_data lane %0d: got %h expected %h",
                                     bad, d_out_data[bad], e.data[bad]);
                        end
                    end
                end
                stall = d_out_valid && !d_out_ready;
                pd = d_out_data;
                pk = d_out_keep;
                pl = d_out_last;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((uq.size() != 0 || dq.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [DI-1:0][31:0] rand_dbeat();
        logic [DI-1:0][31:0] d;
        for (int j = 0; j < DI; j++) d[j] = $urandom;
        return d;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rdy_rand    = 1'b0;
        u_rdy_force = 1'b1;
        d_rdy_force = 1'b1;
        u_lat_en    = 1'b0;
        rst_n       = 1'b0;
        u_in_valid  = 1'b0;
        u_in_data   = '0;
        u_in_keep   = '0;
        u_in_last   = 1'b0;
        d_in_valid  = 1'b0;
        d_in_data   = '0;
        d_in_keep   = '0;
        d_in_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_up_out_valid", u_out_valid, 0);
        check_val("rst_dn_out_valid", d_out_valid, 0);
        check_val("rst_up_in_ready", u_in_ready, 1);
        check_val("rst_dn_in_ready", d_in_ready, 1);
        @(posedge clk);
        #1;

        // Up: 64 sequential elements, full keep, last on beat 8.
        u_lat_en = 1'b1;
        pk_nb = 8;
        for (int i = 0; i < 64; i++) pk_el[i] = i;
        for (int b = 0; b < 8; b++) pk_keep[b] = 8'hFF;
        up_model();
        up_drive_pkt(1'b0);
        wait_drain();

        // Up: 6-beat packet, last beat keep 0F.
        pk_nb = 6;
        for (int i = 0; i < 48; i++) pk_el[i] = 32'h1000 + i;
        for (int b = 0; b < 6; b++) pk_keep[b] = 8'hFF;
        pk_keep[5] = 8'h0F;
        up_model();
        up_drive_pkt(1'b0);
        wait_drain();
        u_lat_en = 1'b0;

        // Up: backpressure with a full output register.
        u_rdy_force = 1'b0;
        @(posedge clk);
        #1;
        pk_nb = 8;
        for (int i = 0; i < 64; i++) pk_el[i] = 32'h2000 + i;
        for (int b = 0; b < 8; b++) pk_keep[b] = 8'hFF;
        up_model();
        fork
            up_drive_pkt(1'b0);
            begin
                int n;
                n = 0;
                while (!u_out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check_val("up_bp_out_valid", u_out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    check_val("up_bp_in_ready", u_in_ready, 0);
                    @(negedge clk);
                end
                u_rdy_force = 1'b1;
            end
        join
        wait_drain();

        // Down: two back-to-back beats, the second last.
        fork
            begin
                d_send(rand_dbeat(), '1, 1'b0);
                d_send(rand_dbeat(), '1, 1'b1);
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    check_val("dn_b2b_out_valid", d_out_valid, 1);
                    if (i == 3) check_val("dn_b2b_in_ready_final", d_in_ready, 1);
                end
            end
        join
        wait_drain();

        // Down: last beat with only the first chunk populated.
        d_send(rand_dbeat(), 32'h000000FF, 1'b1);
        wait_drain();
        // Down: entirely empty last beat.
        d_send(rand_dbeat(), 32'h00000000, 1'b1);
        wait_drain();

        // Up: reset after 2 of 4 beats discards the partial group.
        begin
            logic [UI-1:0][31:0] d;
            for (int j = 0; j < UI; j++) d[j] = 32'hDEAD0000 + j;
            up_beat(d, 8'hFF, 1'b0, 1'b0);
            up_beat(d, 8'hFF, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_mid_up_out_valid", u_out_valid, 0);
        @(posedge clk);
        #1;
        pk_nb = 4;
        for (int i = 0; i < 32; i++) pk_el[i] = 32'h3000 + i;
        for (int b = 0; b < 4; b++) pk_keep[b] = 8'hFF;
        up_model();
        up_drive_pkt(1'b0);
        wait_drain();

        // Randomized traffic with random backpressure.
        rdy_rand = 1'b1;
        for (int p = 0; p < 30; p++) begin
            pk_nb = $urandom_range(1, 10);
            for (int i = 0; i < pk_nb * UI; i++) pk_el[i] = $urandom;
            for (int b = 0; b < pk_nb; b++)
                pk_keep[b] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            up_model();
            up_drive_pkt(1'b1);
        end
        for (int b = 0; b < 40; b++) begin
            logic [DR-1:0][DO-1:0] k;
            for (int c = 0; c < DR; c++) begin
                case ($urandom_range(0, 2))
                    0:       k[c] = 8'h00;
                    1:       k[c] = 8'hFF;
                    default: k[c] = 8'($urandom);
                endcase
            end
            d_send(rand_dbeat(), k, ($urandom_range(0, 2) == 0));
        end
        rdy_rand    = 1'b0;
        u_rdy_force = 1'b1;
        d_rdy_force = 1'b1;
        wait_drain();
        check_val("final_up_queue_empty", uq.size(), 0);
        check_val("final_dn_queue_empty", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ndata_width_resizer.md
Name: ndata_width_resizer

Overview:
- Generic ndata_i stream width converter between an IN_WIDTH-element input and an OUT_WIDTH-element output.
- Supports integer-ratio upsizing (pack R input beats into one output beat) and downsizing (split one input beat into R output beats), with full handshaking and backpressure.
- Sits between stream stages whose lane counts differ.
- Replaces the fixed 8-to-16 converter.

Parameters:
- data_t, logic[31:0], element type carried per lane.
- IN_WIDTH, 8, number of elements per input beat.
- OUT_WIDTH, 16, number of elements per output beat.
- Elaboration error unless one width is an integer multiple of the other.
- RATIO = max/min of the two widths (derived).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in  ndata_i.s  data_t[IN_WIDTH], keep[IN_WIDTH], last, valid, ready  input stream.
- out  ndata_i.m  data_t[OUT_WIDTH], keep[OUT_WIDTH], last, valid, ready  output stream.

Behaviour:
- A transfer occurs on any interface when valid && ready at posedge clk.
- Lane ordering: lower-indexed lanes are earlier in the stream.
- Equal mode (IN_WIDTH == OUT_WIDTH): combinational passthrough of all signals, no state.
- Up mode (OUT = IN*R):
  - Accumulator of R slots plus slot counter 0..R-1, reset 0.
  - Input beat k of a group lands in slot k: out element k*IN_WIDTH+j = in element j; keep likewise.
  - Group completes when the slot counter == R-1 or in.last.
  - On completion, the accumulator merged with the current beat loads the output register. Unfilled slots get keep = 0 (data don't-care), out.last = in.last, the accumulator clears and the counter returns to 0, all in the same cycle.
  - in.ready = !out.valid || out.ready. Combinational from registered state and out.ready only; never depends on in.valid.
  - Latency: 1 cycle from the completing input beat to out.valid.
  - Throughput: one input beat per cycle when out.ready is held high.
- Down mode (IN = OUT*R):
  - Input buffer (data, keep, last, full flag) plus chunk counter 0..R-1, reset 0.
  - out presents chunk c of the buffer: out element j = buffered element c*OUT_WIDTH+j; keep likewise.
  - out.valid = full. out.last = buffered last && chunk is final.
  - Chunk counter increments on each out transfer. After the final chunk transfers, counter = 0 and the buffer empties.
  - in.ready = !full || (final chunk && out.ready). Back-to-back input beats therefore give 100% output utilisation.
  - Latency: 1 cycle from input transfer to first chunk valid.
- Output stability: while out.valid && !out.ready, all out fields hold stable.
- Keep: chunk keep is passed as-is in both modes. No compaction of sparse keep patterns except as described under Optional Feature.
- Reset values: out.valid = 0; all counters 0; buffer/accumulator keep cleared. Data registers are not reset.
- Reset mid-operation: any partial group or unsent chunks are discarded. The first beat after reset is slot/chunk 0.
- Simultaneous output drain and input completion (up mode): the new word loads the output register in the same cycle the old one transfers. No bubble.

Optional Feature:
- Macro: NDATA_RESIZER_DROP_EMPTY_EN. Affects down mode only.
- With the macro: chunks whose keep is all-zero are skipped (not presented), and the counter jumps to the next non-empty chunk.
  - out.last is asserted on the highest-indexed non-empty chunk of a last beat.
  - An entirely empty last beat emits exactly one chunk with keep = 0, last = 1.
  - An entirely empty non-last beat emits nothing and is consumed in one cycle.
- Without the macro: all R chunks are always emitted.

Test Plan:
- Up 8->32, 8 beats carrying elements 0..63, keep all-ones, last on beat 8, out.ready = 1 -> exactly 2 out beats with element i = i, keep = 32'hFFFFFFFF, last only on the 2nd; each appears 1 cycle after beats 4 and 8.
- Up 8->32, 6 beats, beat 6 last with keep = 8'h0F -> 2nd out beat has keep = 32'h00000FFF, last = 1, emitted the cycle after beat 6; next packet starts at slot 0.
- Up 8->32 backpressure: hold out.ready = 0 for 5 cycles with the output register full -> in.ready = 0 throughout, out fields stable; after release all 64 elements arrive in order with no loss or duplication.
- Down 32->8, two back-to-back beats (second last = 1), out.ready = 1 -> 8 consecutive out beats with no gap; in.ready = 1 in the cycle the 4th chunk transfers; last only on the 8th.
- Down 32->8, last beat with keep = 32'h000000FF:
  - macro on -> one chunk, keep = 8'hFF, last = 1;
  - macro off -> 4 chunks, keep FF,00,00,00, last on the 4th.
- Reset: drive rst_n = 0 for one cycle after 2 of 4 up beats -> out.valid = 0 next cycle; a following 4-beat group emits exactly one beat containing only the new data.
